lis3dh_irq_sequencer: RTL

Avalon-MM master that owns the 2-bit LIS3DH interrupt PIO (INT1/INT2 edge-capture PIO) so the Nios does not service it by polling. The block programs the PIO interrupt mask, waits for the PIO irq, reads and clears edge-capture, and pushes a timestamped event into a small FIFO for downstream consumers (DMA/readout logic or a CSR window). It sits between the PIO slave port and the accelerometer readout path.

---
 rtl/lis3dh_seq_pkg.sv | 19 +
 rtl/lis3dh_evt_fifo.sv | 45 ++++
 rtl/lis3dh_irq_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lis3dh_seq_pkg.sv
// Shared types and PIO register offsets for the LIS3DH interrupt sequencer.
package lis3dh_seq_pkg;

    typedef enum logic [2:0] {
        StInit,
        StClr,
        StIdle,
        StMask,
        StRd,
        StCap,
        StAck,
        StPush
    } state_e;

    localparam logic [1:0] PIO_DATA = 2'd0;
    localparam logic [1:0] PIO_MASK = 2'd2;
    localparam logic [1:0] PIO_EDGE = 2'd3;

endpackage

// File: rtl/lis3dh_evt_fifo.sv
// First-word fall-through event FIFO; a pop frees a full slot for a same-cycle push.
module lis3dh_evt_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/lis3dh_irq_sequencer.sv
// Avalon-MM master servicing the LIS3DH INT1/INT2 edge-capture PIO and queueing
// timestamped events for downstream readout.
module lis3dh_irq_sequencer
    import lis3dh_seq_pkg::*;
#(
    parameter int unsigned TS_W      = 16,
    parameter int unsigned DEPTH     = 8,
    parameter logic [1:0]  MASK_INIT = 2'b11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [1:0]      cfg_mask,
    input  logic            cfg_load,
    output logic [1:0]      avm_address,
    output logic            avm_chipselect,
    output logic            avm_write_n,
    output logic [31:0]     avm_writedata,
    input  logic [31:0]     avm_readdata,
    input  logic            pio_irq,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [TS_W+1:0] evt_data,
    output logic            evt_overflow,
    output logic [7:0]      drop_count,
    output logic            busy
);
    state_e          r_state;
    state_e          w_state_d;
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_ts_cap;
    logic [1:0]      r_cap;
    logic            r_pend;
    logic [1:0]      r_pend_mask;
    logic            r_overflow;
    logic [7:0]      r_drop;
    logic            w_cs;
    logic            w_wr;
    logic [1:0]      w_addr;
    logic [31:0]     w_wdata;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic            w_full;
    logic            w_empty;
    logic            w_unused_rdata;

    assign w_unused_rdata = ^avm_readdata[31:2];

    always_comb begin
        w_state_d = r_state;
        w_cs      = 1'b0;
        w_wr      = 1'b0;
        w_addr    = PIO_DATA;
        w_wdata   = '0;
        unique case (r_state)
            StInit: begin
                w_cs      = 1'b1;
                w_wr      = 1'b1;
                w_addr    = PIO_MASK;
                w_wdata   = {30'b0, MASK_INIT};
                w_state_d = StClr;
            end
            StClr: begin
                w_cs      = 1'b1;
                w_wr      = 1'b1;
                w_addr    = PIO_EDGE;
                w_wdata   = 32'h3;
                w_state_d = StIdle;
            end
            StIdle: begin
                if (r_pend)               w_state_d = StMask;
                else if (en && pio_irq)   w_state_d = StRd;
            end
            StMask: begin
                w_cs      = 1'b1;
                w_wr      = 1'b1;
                w_addr    = PIO_MASK;
                w_wdata   = {30'b0, r_pend_mask};
                w_state_d = StClr;
            end
            StRd: begin
                w_cs      = 1'b1;
                w_addr    = PIO_EDGE;
                w_state_d = StCap;
            end
            StCap: begin
                w_state_d = (avm_readdata[1:0] == 2'b00) ? StIdle : StAck;
            end
            StAck: begin
                w_cs      = 1'b1;
                w_wr      = 1'b1;
                w_addr    = PIO_EDGE;
                w_wdata   = 32'h3;
                w_state_d = StPush;
            end
            StPush: begin
                w_state_d = StIdle;
            end
            default: w_state_d = StInit;
        endcase
    end

    // Reset forces the bus idle immediately, even though the state register sits in INIT.
    assign avm_chipselect = w_cs & ~reset;
    assign avm_write_n    = ~(w_wr & ~reset);
    assign avm_address    = reset ? PIO_DATA : w_addr;
    assign avm_writedata  = reset ? 32'h0 : w_wdata;
    assign busy           = (r_state != StIdle);

    assign w_push = (r_state == StPush);
    assign w_pop  = evt_valid && evt_ready;
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StInit;
            r_ts        <= '0;
            r_ts_cap    <= '0;
            r_cap       <= 2'b00;
            r_pend      <= 1'b0;
            r_pend_mask <= 2'b00;
            r_overflow  <= 1'b0;
            r_drop      <= 8'd0;
        end else begin
            r_state <= w_state_d;
            r_ts    <= r_ts + 1'b1;
            if (cfg_load) begin
                r_pend      <= 1'b1;
                r_pend_mask <= cfg_mask;
            end else if (r_state == StMask) begin
                r_pend <= 1'b0;
            end
            if (r_state == StCap) begin
                r_cap    <= avm_readdata[1:0];
                r_ts_cap <= r_ts;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
            end
        end
    end

    assign evt_overflow = r_overflow;
    assign drop_count   = r_drop;
    assign evt_valid    = !w_empty;

    lis3dh_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TS_W + 2)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata ({r_ts_cap, r_cap}),
        .i_pop   (w_pop),
        .o_rdata (evt_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
